// File: rtl/muldiv_pkg.sv
// Operation/state encodings and operand-signedness helpers for the RV32M unit.
package muldivPkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } md_op;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state;

    function automatic logic is_signed_rs1(input md_op op);
        return op inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic is_signed_rs2(input md_op op);
        return op inside {MUL, MULH, DIV, REM};
    endfunction

    function automatic logic is_div(input md_op op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/rysy_pkg.sv
// Core-wide configuration shared by the rysy execution units.
package rysyPkg;
    localparam int unsigned REG_LEN = 32;
endpackage

// File: rtl/muldiv_unit_fixup.sv
// Sign restoration and result selection from the raw magnitude datapath value.
module muldiv_fixup
    import muldivPkg::*;
#(
    parameter int unsigned REG_LEN = rysyPkg::REG_LEN
) (
    input  md_op                   op,
    input  logic [2*REG_LEN-1:0]   raw,
    input  logic                   neg_res,
    input  logic                   neg_rem,
    output logic [REG_LEN-1:0]     result
);

    logic [2*REG_LEN-1:0] prod_s;

    // Divide ops keep {remainder, quotient} in the same register as the product.
    always_comb begin
        prod_s = neg_res ? -raw : raw;
        result = '0;
        case (op)
            MUL:                 result = prod_s[REG_LEN-1:0];
            MULH, MULHSU, MULHU: result = prod_s[2*REG_LEN-1:REG_LEN];
            DIV, DIVU:           result = neg_res ? -raw[REG_LEN-1:0] : raw[REG_LEN-1:0];
            default:             result = neg_rem ? -raw[2*REG_LEN-1:REG_LEN]
                                                  : raw[2*REG_LEN-1:REG_LEN];
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with a single-cycle fast path for divide-by-zero and signed overflow.
module muldiv_unit
    import muldivPkg::*;
#(
    parameter int unsigned REG_LEN = rysyPkg::REG_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  md_op               op,
    input  logic [REG_LEN-1:0] alu_in1,
    input  logic [REG_LEN-1:0] alu_in2,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [REG_LEN-1:0] result
);

    localparam int unsigned CW = $clog2(REG_LEN + 1);
    localparam logic [REG_LEN-1:0] MIN_NEG = {1'b1, {(REG_LEN-1){1'b0}}};

    md_state              state, state_nx;
    md_op                 op_q;
    logic [2*REG_LEN-1:0] prod_q, prod_nx;
    logic [REG_LEN-1:0]   opb_q, result_q, fixed, fast_res, mag1, mag2;
    logic [CW-1:0]        cnt_q;
    logic                 neg_res_q, neg_rem_q, s1, s2;
    logic                 accept, take_fast, finish, div_zero, div_ovf;
    logic [REG_LEN:0]     rem_sh, diff, sum;

    always_comb begin
        s1       = is_signed_rs1(op) && alu_in1[REG_LEN-1];
        s2       = is_signed_rs2(op) && alu_in2[REG_LEN-1];
        mag1     = s1 ? -alu_in1 : alu_in1;
        mag2     = s2 ? -alu_in2 : alu_in2;
        div_zero = is_div(op) && (alu_in2 == '0);
        div_ovf  = (op == DIV || op == REM) && (alu_in1 == MIN_NEG) && (alu_in2 == '1);
        fast_res = '0;
        if (div_zero)
            fast_res = (op == DIV || op == DIVU) ? '1 : alu_in1;
        else if (div_ovf)
            fast_res = (op == DIV) ? MIN_NEG : '0;
    end

    // prod_q starts as {0, rs1 magnitude}: multiplier for MUL*, dividend for DIV*.
    always_comb begin
        rem_sh = prod_q[2*REG_LEN-1:REG_LEN-1];
        diff   = rem_sh - {1'b0, opb_q};
        sum    = {1'b0, prod_q[2*REG_LEN-1:REG_LEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
        if (is_div(op_q)) begin
            if (!diff[REG_LEN])
                prod_nx = {diff[REG_LEN-1:0], prod_q[REG_LEN-2:0], 1'b1};
            else
                prod_nx = {prod_q[2*REG_LEN-2:0], 1'b0};
        end else begin
            prod_nx = {sum, prod_q[REG_LEN-1:1]};
        end
    end

    muldiv_fixup #(.REG_LEN(REG_LEN)) u_fixup (
        .op      (op_q),
        .raw     (prod_nx),
        .neg_res (neg_res_q),
        .neg_rem (neg_rem_q),
        .result  (fixed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        take_fast = 1'b0;
        finish    = 1'b0;
        case (state)
            CALC: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (cnt_q == CW'(1)) begin
                    state_nx = DONE;
                    finish   = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                if (start && !flush) begin
                    accept    = 1'b1;
                    take_fast = div_zero || div_ovf;
                    state_nx  = (div_zero || div_ovf) ? DONE : CALC;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= MUL;
            prod_q    <= '0;
            opb_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else if (accept) begin
            op_q      <= op;
            prod_q    <= {{REG_LEN{1'b0}}, mag1};
            opb_q     <= mag2;
            neg_res_q <= s1 ^ s2;
            neg_rem_q <= s1;
            cnt_q     <= CW'(REG_LEN);
            if (take_fast)
                result_q <= fast_res;
        end else if (state == CALC && !flush) begin
            prod_q <= prod_nx;
            cnt_q  <= cnt_q - CW'(1);
            if (finish)
                result_q <= fixed;
        end
    end

    assign busy   = (state == CALC);
    assign done   = (state == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed checks of muldiv_unit against a 64-bit arithmetic reference.
module tb_muldiv_unit;
    import muldivPkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    md_op         op_i = MUL;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         busy, done;
    logic [W-1:0] result;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] last_res = '0;

    typedef struct {
        md_op         o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        int           lat;
    } vec_t;

    vec_t dir [14];

    always #5 clk = ~clk;

    muldiv_unit #(.REG_LEN(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op_i),
        .alu_in1 (in1),
        .alu_in2 (in2),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    function automatic logic [W-1:0] model(input md_op o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (o)
            MUL:    begin p = 64'(sa * sb); return p[31:0];  end
            MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(input md_op o, input logic [W-1:0] a, input logic [W-1:0] b);
        if (o inside {DIV, DIVU, REM, REMU} && b == 0) return 1;
        if (o inside {DIV, REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    // Sample k is taken 1 time unit after the (k-1)th edge following the accept edge.
    task automatic run_op(input md_op o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1;
        op_i  = o;
        in1   = a;
        in2   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_i  = md_op'($urandom_range(0, 7));
        in1   = $urandom;
        in2   = $urandom;
        res   = result;
        lat   = 0;
        nbusy = 0;
        for (int i = 1; i <= 100; i++) begin
            if (busy) nbusy++;
            if (done) begin
                lat = i;
                res = result;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (result !== '0) begin miscompares++; $display("FAIL reset_result: got %h expected 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
    endtask

    task automatic test_directed();
        logic [W-1:0] res;
        int lat, nbusy;
        dir[0]  = '{MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        dir[1]  = '{MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        dir[2]  = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        dir[3]  = '{MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33};
        dir[4]  = '{DIVU,   32'd100,        32'd7,         32'd14,        33};
        dir[5]  = '{REMU,   32'd100,        32'd7,         32'd2,         33};
        dir[6]  = '{DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        dir[7]  = '{REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        dir[8]  = '{DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        dir[9]  = '{REM,    32'd5,          32'd0,         32'd5,         1};
        dir[10] = '{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        dir[11] = '{REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        dir[12] = '{DIVU,   32'd9,          32'd0,         32'hFFFF_FFFF, 1};
        dir[13] = '{REMU,   32'd9,          32'd0,         32'd9,         1};
        for (int i = 0; i < 14; i++) begin
            run_op(dir[i].o, dir[i].a, dir[i].b, res, lat, nbusy);
            vectors++;
            if (res !== dir[i].r) begin
                miscompares++;
                $display("FAIL dir%0d_result: got %h expected %h", i, res, dir[i].r);
            end
            vectors++;
            if (lat !== dir[i].lat) begin
                miscompares++;
                $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, dir[i].lat);
            end
            vectors++;
            if (nbusy !== ((dir[i].lat == 1) ? 0 : 32)) begin
                miscompares++;
                $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, nbusy, (dir[i].lat == 1) ? 0 : 32);
            end
            last_res = dir[i].r;
        end
    endtask

    task automatic test_random(input int n);
        logic [W-1:0] a, b, res, exp_r;
        md_op o;
        int lat, nbusy, el;
        for (int i = 0; i < n; i++) begin
            o = md_op'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'($urandom_range(1, 20));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = a ^ 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            exp_r = model(o, a, b);
            el    = exp_lat(o, a, b);
            run_op(o, a, b, res, lat, nbusy);
            vectors++;
            if (res !== exp_r) begin
                miscompares++;
                $display("FAIL rand_result op=%0d a=%h b=%h: got %h expected %h", o, a, b, res, exp_r);
            end
            vectors++;
            if (lat !== el) begin
                miscompares++;
                $display("FAIL rand_latency op=%0d: got %0d expected %0d", o, lat, el);
            end
            last_res = exp_r;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res;
        int lat, nbusy;
        run_op(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, res, lat, nbusy);
        run_op(DIV, 32'hFFFF_FF00, 32'd16, res, lat, nbusy);
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
        vectors++; if (nbusy !== 32) begin miscompares++; $display("FAIL b2b_busy_cycles: got %0d expected 32", nbusy); end
        vectors++; if (res !== 32'hFFFF_FFF0) begin miscompares++; $display("FAIL b2b_result: got %h expected fffffff0", res); end
        run_op(REMU, 32'd3, 32'd0, res, lat, nbusy);
        run_op(DIVU, 32'd3, 32'd0, res, lat, nbusy);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL b2b_fast_latency: got %0d expected 1", lat); end
        vectors++; if (res !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL b2b_fast_result: got %h expected ffffffff", res); end
        last_res = 32'hFFFF_FFFF;
    endtask

    task automatic test_flush();
        logic [W-1:0] res, a, b;
        int lat, nbusy, ndone;
        @(negedge clk);
        start = 1'b1; op_i = MUL; in1 = $urandom; in2 = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy: got %b expected 0", busy); end
        vectors++; if (result !== last_res) begin miscompares++; $display("FAIL flush_result_hold: got %h expected %h", result, last_res); end
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            @(posedge clk);
            #1;
        end
        vectors++; if (ndone !== 0) begin miscompares++; $display("FAIL flush_no_done: got %0d expected 0", ndone); end
        vectors++; if (result !== last_res) begin miscompares++; $display("FAIL flush_result_later: got %h expected %h", result, last_res); end
        a = $urandom; b = $urandom;
        run_op(MULH, a, b, res, lat, nbusy);
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL post_flush_latency: got %0d expected 33", lat); end
        vectors++; if (res !== model(MULH, a, b)) begin miscompares++; $display("FAIL post_flush_result: got %h expected %h", res, model(MULH, a, b)); end
        last_res = model(MULH, a, b);
    endtask

    task automatic test_start_while_busy();
        logic [W-1:0] a, b, res;
        int lat, ndone;
        a = $urandom; b = 32'($urandom_range(1, 1000));
        @(negedge clk);
        start = 1'b1; op_i = DIVU; in1 = a; in2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0; ndone = 0; res = '0;
        for (int i = 1; i <= 50; i++) begin
            if (done) begin
                ndone++;
                if (lat == 0) begin lat = i; res = result; end
            end
            @(negedge clk);
            start = (i == 5);
            op_i  = MUL;
            in1   = $urandom;
            in2   = 32'd0;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL busy_start_done_count: got %0d expected 1", ndone); end
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL busy_start_latency: got %0d expected 33", lat); end
        vectors++; if (res !== a / b) begin miscompares++; $display("FAIL busy_start_result: got %h expected %h", res, a / b); end
        last_res = a / b;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] a, b, res;
        int lat, nbusy;
        @(negedge clk);
        start = 1'b1; op_i = MULHU; in1 = $urandom; in2 = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_done: got %b expected 0", done); end
        vectors++; if (result !== '0) begin miscompares++; $display("FAIL midrst_result: got %h expected 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        a = $urandom; b = $urandom;
        run_op(REM, a, b, res, lat, nbusy);
        vectors++; if (res !== model(REM, a, b)) begin miscompares++; $display("FAIL post_rst_result: got %h expected %h", res, model(REM, a, b)); end
        vectors++; if (lat !== exp_lat(REM, a, b)) begin miscompares++; $display("FAIL post_rst_latency: got %0d expected %0d", lat, exp_lat(REM, a, b)); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(60);
        test_back_to_back();
        test_flush();
        test_start_while_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit that consumes the same two ALU operands (`alu_in1`, `alu_in2`) produced by the operand-select muxes. It runs in parallel with the single-cycle ALU. It holds `busy` to stall the pipeline for the duration of a multi-cycle operation, then returns a registered result with a one-cycle `done` pulse for the writeback mux.

## Interface
Parameters:
- `REG_LEN`, default 32 (from `rysyPkg`), operand and result width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled only when not `busy`.
- `op`  in  3  `muldivPkg::md_op`: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `alu_in1`  in  REG_LEN  operand 1 (rs1 value).
- `alu_in2`  in  REG_LEN  operand 2 (rs2 value).
- `flush`  in  1  synchronous kill of the in-flight operation.
- `busy`  out  1  operation in progress; pipeline stall request.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  REG_LEN  registered result; held until the next accepted `start`.

## Operation
- FSM states: IDLE, CALC, DONE (`muldivPkg::md_state`).
- **IDLE or DONE with `start`=1:**
  - Latch `op`.
  - Latch operand magnitudes: two's-complement negate rs1 if it is signed for this op and negative; same rule for rs2.
  - Latch the result-sign flags.
  - Load the iteration counter with REG_LEN, then go to CALC.
  - MULHSU treats rs1 as signed and rs2 as unsigned. MULHU and DIVU/REMU treat both operands as unsigned. All other ops treat both as signed.
- **Fast path (divide ops only), go straight to DONE:**
  - Divide by zero (rs2 == 0): DIV/DIVU result = all ones; REM/REMU result = rs1.
  - Signed overflow (DIV/REM, rs1 == 0x80000000, rs2 == 0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- **CALC, one iteration per cycle, counter decrements:**
  - Multiply: shift-add into a 2·REG_LEN product register, LSB-first on the multiplier.
  - Divide: restoring division. Shift {remainder, quotient} left by 1, trial-subtract the divisor, and keep the result if it is non-negative (quotient bit = 1).
  - When the counter reaches 1, transition to DONE and load `result` with the sign-fixed value:
    - MUL: low half of the product, negated as 2·REG_LEN if the signs differ.
    - MULH/MULHSU/MULHU: high half of the product.
    - DIV: quotient, negated if the operand signs differ.
    - REM: remainder, taking the sign of the dividend.
- **DONE:** `done`=1 for exactly this cycle. Without `start`, return to IDLE next cycle. With `start`, accept the new operation (back-to-back).
- **Flush:** `flush`=1 in CALC returns the FSM to IDLE at the next edge. No `done` is produced and `result` is unchanged. `flush` has priority over `start` and over CALC completion.
- **`start` while `busy`:** ignored.
- **Reset (asynchronous, any state, including mid-operation):** state = IDLE, `busy`=0, `done`=0, `result`=0, counter = 0, internal registers = 0.

## Timing
- `start` is accepted at edge N.
- Normal path:
  - `busy`=1 in cycles N+1 .. N+REG_LEN (CALC).
  - `done`=1 and `result` valid in cycle N+REG_LEN+1 (N+33 for 32-bit).
- Fast path: `done`=1 and `result` valid in cycle N+1; `busy` is never asserted.
- `busy` is a registered output, decoded from the state (CALC); no combinational path from `start`.
- `done` is registered (state == DONE). `result` changes only on the edge that enters DONE, or on reset.
- Back-to-back: `start` in the DONE cycle puts the unit in CALC in the following cycle.

## Structure
- `muldivPkg`: `md_op` enum (3 bits, order as listed above), `md_state` enum, and helper functions `is_signed_rs1(op)`, `is_signed_rs2(op)` and `is_div(op)`.
- REG_LEN is imported from `rysyPkg`.
- Single module with one sub-module: `muldiv_fixup`, combinational sign and result-select logic (raw product/quotient/remainder plus flags in, `result` out). It can be tested standalone.

## Test plan
- MUL with rs1 = 7, rs2 = 0xFFFFFFFD (−3), `start` at N -> `busy` high N+1..N+32; `done` and `result` = 0xFFFFFFEB at N+33.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14. REMU 100/7 -> 2. DIV −7/2 -> 0xFFFFFFFD. REM −7/2 -> 0xFFFFFFFF. Each has `done` at N+33.
- Divide by zero:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; `done` at N+1; `busy` never high.
  - Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Flush at N+10 -> CALC exits, `busy` low at N+11, no `done`, `result` holds its previous value. `start` at N+11 completes normally at N+44.
- `rst_n` low mid-CALC -> `busy`, `done` and `result` go to 0 immediately. Next `start` after release behaves normally. A `start` pulsed while `busy` is ignored (no extra `done`).
